estagio_ex: RTL and testbench

Execute stage of the 32-bit pipelined processor, directly upstream of the memory stage, which it feeds through the EX/MEM register.
- Computes ALU result, zero flag, branch target, destination register and store data from ID/EX values.
- Registers everything into EX/MEM with the memory/writeback control bits.
- Contains an iterative shift-add multiplier; it stalls the upstream pipeline while busy.

---
 rtl/estagio_ex_pkg.sv | 13 +
 rtl/estagio_ex_if.sv | 24 ++
 rtl/estagio_ex_multiplicador_seq.sv | 43 ++++
 rtl/estagio_ex.sv | 78 +++++++
 tb/tb_estagio_ex.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/estagio_ex_pkg.sv
// estagio_ex_pkg: ALU operation codes and execute-stage FSM encodings
package estagio_ex_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, MUL_DONE = 2'd2} estado_t;
endpackage

// File: rtl/estagio_ex_if.sv
// estagio_ex_if: ID/EX inputs, EX/MEM outputs and stall of the execute stage
interface estagio_ex_if #(parameter int DATA_W = 32);
    logic              flush, valid_in, ALUSrc, regDst;
    logic              memRead, memWrite, branch, regWrite, memToReg;
    logic [DATA_W-1:0] PC, dado1, dado2, imediato;
    logic [4:0]        RT, RD;
    logic [3:0]        ALUOp;
    logic              stall, zero_out;
    logic              memRead_out, memWrite_out, branch_out, regWrite_out, memToReg_out;
    logic [DATA_W-1:0] saidaULA_out, dadoEscrita_out, PCdesvio_out;
    logic [4:0]        RD_out;
    modport master (
        output flush, valid_in, ALUSrc, regDst, memRead, memWrite, branch, regWrite, memToReg,
               PC, dado1, dado2, imediato, RT, RD, ALUOp,
        input  stall, zero_out, memRead_out, memWrite_out, branch_out, regWrite_out, memToReg_out,
               saidaULA_out, dadoEscrita_out, PCdesvio_out, RD_out
    );
    modport slave (
        input  flush, valid_in, ALUSrc, regDst, memRead, memWrite, branch, regWrite, memToReg,
               PC, dado1, dado2, imediato, RT, RD, ALUOp,
        output stall, zero_out, memRead_out, memWrite_out, branch_out, regWrite_out, memToReg_out,
               saidaULA_out, dadoEscrita_out, PCdesvio_out, RD_out
    );
endinterface

// File: rtl/estagio_ex_multiplicador_seq.sv
// multiplicador_seq: iterative shift-add multiplier, one partial product per edge
module multiplicador_seq #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] acc, mcand, mplier;
    // done marks the iteration that completes the product at this edge
    assign done    = busy && count == LAST;
    assign product = acc;
    always_ff @(posedge clock) begin
        if (clear) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= mplier[0] ? acc + mcand : acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            busy   <= !done;
        end
    end
endmodule

// File: rtl/estagio_ex.sv
// estagio_ex: execute stage; ALU, branch target and EX/MEM register, stalls on MUL
module estagio_ex
    import estagio_ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic         clock,
    input logic         reset,
    estagio_ex_if.slave ex
);
    estado_t           estado, proximo;
    logic              inicia, ultimo, mul_busy, captura;
    logic [DATA_W-1:0] a, b, alu, resultado, produto;
    logic [3:0]        op;
    assign a  = ex.dado1;
    assign b  = ex.ALUSrc ? ex.imediato : ex.dado2;
    assign op = ex.ALUOp;
    always_comb begin
        alu = op == ALU_ADD ? a + b :
              op == ALU_SUB ? a - b :
              op == ALU_AND ? a & b :
              op == ALU_OR  ? a | b :
              op == ALU_SLT ? DATA_W'($signed(a) < $signed(b)) :
              op == ALU_NOR ? ~(a | b) :
              op == ALU_SLL ? a << b[4:0] :
              op == ALU_SRL ? a >> b[4:0] : '0;
    end
    multiplicador_seq #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clock  (clock),
        .clear  (reset || ex.flush),
        .start  (inicia),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (ultimo),
        .product(produto)
    );
    always_ff @(posedge clock) estado <= reset ? IDLE : proximo;
    always_comb begin
        proximo = ex.flush           ? IDLE :
                  estado == IDLE     ? (inicia ? MUL_BUSY : IDLE) :
                  estado == MUL_BUSY ? (ultimo ? MUL_DONE : MUL_BUSY) : IDLE;
    end
    // a flushed MUL never launches; only IDLE and DONE hand a real instruction to EX/MEM
    always_comb begin
        inicia    = estado == IDLE && ex.valid_in && op == ALU_MUL && !ex.flush;
        ex.stall  = inicia || mul_busy;
        captura   = ex.valid_in && !ex.flush &&
                    (estado == IDLE ? op != ALU_MUL : estado == MUL_DONE);
        resultado = estado == MUL_DONE ? produto : alu;
    end
    always_ff @(posedge clock) begin
        if (reset || !captura) begin
            ex.saidaULA_out    <= '0;
            ex.dadoEscrita_out <= '0;
            ex.PCdesvio_out    <= '0;
            ex.RD_out          <= '0;
            ex.zero_out        <= 1'b0;
            ex.memRead_out     <= 1'b0;
            ex.memWrite_out    <= 1'b0;
            ex.branch_out      <= 1'b0;
            ex.regWrite_out    <= 1'b0;
            ex.memToReg_out    <= 1'b0;
        end else begin
            ex.saidaULA_out    <= resultado;
            ex.dadoEscrita_out <= ex.dado2;
            ex.PCdesvio_out    <= ex.PC + (ex.imediato << 2);
            ex.RD_out          <= ex.regDst ? ex.RD : ex.RT;
            ex.zero_out        <= resultado == '0;
            ex.memRead_out     <= ex.memRead;
            ex.memWrite_out    <= ex.memWrite;
            ex.branch_out      <= ex.branch;
            ex.regWrite_out    <= ex.regWrite;
            ex.memToReg_out    <= ex.memToReg;
        end
    end
endmodule

// File: tb/tb_estagio_ex.sv
// tb_estagio_ex: directed vectors for the execute stage with hand-computed results
module tb_estagio_ex;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   erros  = 0;
    estagio_ex_if ex ();
    estagio_ex dut (.clock(clock), .reset(reset), .ex(ex));
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            erros++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic limpa();
        ex.flush = 0; ex.valid_in = 0; ex.ALUSrc = 0; ex.regDst = 0;
        ex.memRead = 0; ex.memWrite = 0; ex.branch = 0; ex.regWrite = 0; ex.memToReg = 0;
        ex.PC = 0; ex.dado1 = 0; ex.dado2 = 0; ex.imediato = 0;
        ex.RT = 0; ex.RD = 0; ex.ALUOp = 0;
    endtask

    task automatic apresenta(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        limpa();
        ex.valid_in = 1; ex.ALUOp = op; ex.dado1 = a; ex.dado2 = b;
        ex.regWrite = 1; ex.regDst = 1; ex.RD = 5'd5;
    endtask

    task automatic executa_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        apresenta(4'd8, a, b);
        for (int i = 0; i < 33; i++) begin
            #1;
            verifica({tag, "_stall"}, 32'(ex.stall), 1);
            tick();
            verifica({tag, "_bolha"}, 32'(ex.regWrite_out), 0);
        end
        verifica({tag, "_done_stall"}, 32'(ex.stall), 0);
        tick();
        verifica({tag, "_res"}, ex.saidaULA_out, exp);
        verifica({tag, "_rw"}, 32'(ex.regWrite_out), 1);
        verifica({tag, "_rd"}, 32'(ex.RD_out), 5);
        verifica({tag, "_zero"}, 32'(ex.zero_out), 32'(exp == 0));
        limpa();
    endtask

    logic [3:0]  t_op  [10] = '{4'd2, 4'd3, 4'd5, 4'd4, 4'd4, 4'd6, 4'd7, 4'd9, 4'd0, 4'd1};
    logic [31:0] t_a   [10] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'h1,
                                32'h1, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_b   [10] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'h1, 32'hFFFFFFFF,
                                32'h24, 32'd31, 32'h5678, 32'h1, 32'h1};
    logic [31:0] t_exp [10] = '{32'hF000, 32'hFFF0, 32'hFFFF000F, 32'h1, 32'h0,
                                32'h10, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF};

    initial begin
        limpa();
        tick(); tick();
        reset = 0;
        verifica("rst_ini_ula", ex.saidaULA_out, 0);
        verifica("rst_ini_stall", 32'(ex.stall), 0);

        apresenta(4'd0, 32'd5, 32'd7);
        ex.RD = 5'd3; ex.RT = 5'd9;
        #1 verifica("add_stall", 32'(ex.stall), 0);
        tick();
        verifica("add_ula", ex.saidaULA_out, 12);
        verifica("add_rd", 32'(ex.RD_out), 3);
        verifica("add_zero", 32'(ex.zero_out), 0);
        verifica("add_rw", 32'(ex.regWrite_out), 1);
        verifica("add_mw", 32'(ex.memWrite_out), 0);
        ex.regDst = 0;
        tick();
        verifica("add_rt", 32'(ex.RD_out), 9);

        apresenta(4'd8, 32'd2, 32'd3);
        #1 verifica("mul_ini_stall", 32'(ex.stall), 1);
        for (int i = 0; i < 11; i++) tick();
        reset = 1;
        limpa();
        tick(); tick();
        reset = 0;
        verifica("rst_ula", ex.saidaULA_out, 0);
        verifica("rst_rw", 32'(ex.regWrite_out), 0);
        verifica("rst_pc", ex.PCdesvio_out, 0);
        verifica("rst_stall", 32'(ex.stall), 0);
        verifica("rst_fsm", 32'(dut.estado), 0);

        limpa();
        ex.valid_in = 1; ex.ALUOp = 4'd1; ex.dado1 = 32'h1234; ex.dado2 = 32'h1234;
        ex.branch = 1; ex.PC = 32'h100; ex.imediato = 32'd3;
        tick();
        verifica("sub_zero", 32'(ex.zero_out), 1);
        verifica("sub_pc", ex.PCdesvio_out, 32'h10C);
        verifica("sub_br", 32'(ex.branch_out), 1);
        verifica("sub_ula", ex.saidaULA_out, 0);

        limpa();
        ex.valid_in = 1; ex.ALUSrc = 1; ex.dado1 = 32'h40; ex.imediato = 32'hFFFFFFFC;
        ex.dado2 = 32'hDEAD; ex.memWrite = 1;
        tick();
        verifica("sw_ula", ex.saidaULA_out, 32'h3C);
        verifica("sw_dado", ex.dadoEscrita_out, 32'hDEAD);
        verifica("sw_mw", 32'(ex.memWrite_out), 1);
        verifica("sw_pc", ex.PCdesvio_out, 32'hFFFFFFF0);
        verifica("sw_rw", 32'(ex.regWrite_out), 0);

        for (int i = 0; i < 10; i++) begin
            apresenta(t_op[i], t_a[i], t_b[i]);
            tick();
            verifica($sformatf("alu%0d_res", i), ex.saidaULA_out, t_exp[i]);
            verifica($sformatf("alu%0d_zero", i), 32'(ex.zero_out), 32'(t_exp[i] == 0));
        end

        apresenta(4'd0, 32'd1, 32'd1);
        ex.valid_in = 0; ex.memRead = 1; ex.memToReg = 1;
        tick();
        verifica("bolha_rw", 32'(ex.regWrite_out), 0);
        verifica("bolha_mr", 32'(ex.memRead_out), 0);
        verifica("bolha_m2r", 32'(ex.memToReg_out), 0);
        verifica("bolha_ula", ex.saidaULA_out, 0);

        executa_mul("mul_ff3", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        executa_mul("mul_ovf", 32'h10000, 32'h10000, 32'h0);
        executa_mul("mul_ab", 32'h1234, 32'h10, 32'h12340);

        apresenta(4'd8, 32'd9, 32'd9);
        for (int i = 0; i < 6; i++) tick();
        verifica("fl_busy_stall", 32'(ex.stall), 1);
        ex.flush = 1;
        tick();
        apresenta(4'd0, 32'd1, 32'd2);
        #1 verifica("fl_stall", 32'(ex.stall), 0);
        verifica("fl_bolha", 32'(ex.regWrite_out), 0);
        tick();
        verifica("fl_add", ex.saidaULA_out, 3);
        verifica("fl_add_rw", 32'(ex.regWrite_out), 1);

        apresenta(4'd8, 32'd4, 32'd4);
        ex.flush = 1;
        #1 verifica("fl_idle_stall", 32'(ex.stall), 0);
        tick();
        limpa();
        #1 verifica("fl_idle_fsm", 32'(dut.estado), 0);
        verifica("fl_idle_bolha", 32'(ex.regWrite_out), 0);
        verifica("fl_idle_stall2", 32'(ex.stall), 0);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end
endmodule
